// File: rtl/conf_disp_accumulate_pkg.sv
// Shared types for the disparity-filter blocks: default widths, the sum width
// helper and the (confidence, product) pair stored in the sliding window.
package disp_filter_pkg;
    localparam int DISP_BITS_DEF = 5;
    localparam int CONF_BITS_DEF = 5;

    function automatic int sum_width(input int disp_bits);
        return 8 + disp_bits;
    endfunction

    // Field widths match the divider inputs for the default disparity width.
    typedef struct packed {
        logic [7:0]                          conf;
        logic [sum_width(DISP_BITS_DEF)-1:0] prod;
    } conf_disp_pair_t;
endpackage

// File: rtl/conf_disp_accumulate_if.sv
// Pixel-in / windowed-sums-out bundle of the confidence-weighted accumulator.
interface conf_disp_accumulate_if
    import disp_filter_pkg::*;
#(
    parameter int disp_bits = DISP_BITS_DEF,
    parameter int conf_bits = CONF_BITS_DEF
);
    logic [disp_bits-1:0]            in_disp;
    logic [conf_bits-1:0]            in_conf;
    logic                            in_valid;
    logic                            in_sol;
    logic [7:0]                      out_conf;
    logic [sum_width(disp_bits)-1:0] out_conf_disp;
    logic                            out_valid;

    modport master (output in_disp, in_conf, in_valid, in_sol,
                    input  out_conf, out_conf_disp, out_valid);
    modport slave  (input  in_disp, in_conf, in_valid, in_sol,
                    output out_conf, out_conf_disp, out_valid);
endinterface

// File: rtl/conf_disp_window_shift.sv
// Depth-configurable shift register of (conf, prod) pairs; the oldest entry is
// presented on evicted so the caller can subtract it from its running sums.
module conf_disp_window_shift
    import disp_filter_pkg::*;
#(
    parameter int depth = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            shift,
    input  logic            clear,
    input  conf_disp_pair_t din,
    output conf_disp_pair_t evicted
);
    conf_disp_pair_t r_win [depth];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) r_win[i] <= '0;
        end else if (clear) begin
            for (int i = 1; i < depth; i++) r_win[i] <= '0;
            r_win[0] <= din;
        end else if (shift) begin
            for (int i = 1; i < depth; i++) r_win[i] <= r_win[i-1];
            r_win[0] <= din;
        end
    end

    assign evicted = r_win[depth-1];
endmodule

// File: rtl/conf_disp_accumulate.sv
// Sliding-window confidence and confidence*disparity sums for the divider.
// Optional low-confidence rejection is enabled by defining CONF_THRESH_EN.
module conf_disp_accumulate
    import disp_filter_pkg::*;
#(
    parameter int disp_bits   = DISP_BITS_DEF,
    parameter int conf_bits   = CONF_BITS_DEF,
    parameter int win_len     = 8,
    parameter int conf_thresh = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    conf_disp_accumulate_if.slave  bus
);
    localparam int SW = sum_width(disp_bits);

    if (win_len < 1 || win_len * ((1 << conf_bits) - 1) > 255)
        $error("win_len*(2^conf_bits-1) must be in 1..255");
    if (disp_bits < 1 || disp_bits > DISP_BITS_DEF || conf_bits < 1 || conf_bits > 8)
        $error("disp_bits/conf_bits outside the range the window pair supports");
    if (conf_thresh < 0 || conf_thresh > 255)
        $error("conf_thresh must fit 8 bits");
    if ($bits(bus.in_disp) != disp_bits || $bits(bus.in_conf) != conf_bits)
        $error("interface widths do not match module parameters");

    logic [7:0]      w_conf_eff;
    logic [SW-1:0]   w_prod;
    conf_disp_pair_t w_evicted;
    logic            w_clear;

`ifdef CONF_THRESH_EN
    assign w_conf_eff = (8'(bus.in_conf) < 8'(conf_thresh)) ? 8'd0 : 8'(bus.in_conf);
`else
    assign w_conf_eff = 8'(bus.in_conf);
`endif
    assign w_prod = SW'(w_conf_eff) * SW'(bus.in_disp);

    logic            r_s1_valid;
    logic            r_s1_sol;
    conf_disp_pair_t r_s1_pair;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sol   <= 1'b0;
            r_s1_pair  <= '0;
        end else begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sol  <= bus.in_sol;
                r_s1_pair <= '{conf: w_conf_eff, prod: w_prod};
            end
        end
    end

    assign w_clear = r_s1_valid & r_s1_sol;

    conf_disp_window_shift #(.depth(win_len)) u_window (
        .clk     (clk),
        .reset   (reset),
        .shift   (r_s1_valid),
        .clear   (w_clear),
        .din     (r_s1_pair),
        .evicted (w_evicted)
    );

    logic [7:0]    r_sum_conf;
    logic [SW-1:0] r_sum_cd;
    logic          r_out_valid;

    // On sol the sums restart from the new pair; otherwise add newest, drop oldest.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum_conf  <= '0;
            r_sum_cd    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                if (r_s1_sol) begin
                    r_sum_conf <= r_s1_pair.conf;
                    r_sum_cd   <= r_s1_pair.prod;
                end else begin
                    r_sum_conf <= r_sum_conf + r_s1_pair.conf - w_evicted.conf;
                    r_sum_cd   <= r_sum_cd + r_s1_pair.prod - w_evicted.prod;
                end
            end
        end
    end

    assign bus.out_conf      = r_sum_conf;
    assign bus.out_conf_disp = r_sum_cd;
    assign bus.out_valid     = r_out_valid;
endmodule
